operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-side operand fetch stage of the CPU pipeline. It accepts one fetched instruction at a time over a valid/ready handshake and drives the single-port register file's read request. It captures both source operands one cycle later and presents instruction, PC, operands and destination register to the execute stage. It also owns the register file's write port: writeback requests from later stages pass through it, always take priority over reads, and are forwarded into captured or held operands so execute never sees a stale value.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of any in-flight instruction.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- wb_valid  in  1  writeback request; always accepted, never stalled.
- wb_reg  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- rf_regA, rf_regB  out  5  read addresses = rs (bits 25:21), rt (bits 20:16) of held instruction.
- rf_regW  out  5  = wb_reg (combinational).
- rf_dataIn  out  32  = wb_data (combinational).
- rf_we  out  1  = wb_valid (combinational).
- rf_re  out  1  read strobe.
- rf_outA, rf_outB  in  32  register file read data, valid the cycle after an accepted read.
- out_valid  out  1  operands ready for execute.
- out_ready  in  1  execute accepts.
- out_instr, out_pc  out  32  held instruction and PC.
- out_opA, out_opB  out  32  rs and rt operand values.
- out_dest  out  5  destination register; 0 means no write.

## Operation
- FSM states and transitions:
  - IDLE: go to READ on in_valid && in_ready.
  - READ: go to CAPTURE if !wb_valid, else stay in READ.
  - CAPTURE: always go to HOLD.
  - HOLD: go to IDLE on out_ready.
- IDLE: in_ready=1. On accept, latch in_instr and in_pc.
- READ:
  - rf_re = !wb_valid.
  - A cycle with wb_valid high is a lost read slot; the stage stays in READ and retries.
- CAPTURE:
  - Latch out_opA = rf_outA and out_opB = rf_outB, with forwarding.
  - Forwarding: if wb_valid && wb_reg != 0 && wb_reg == rs, latch wb_data instead for A. Same rule independently for rt/B.
- HOLD:
  - out_valid=1; outputs stable until out_ready.
  - A writeback matching rs or rt (nonzero) updates the held operand at that edge, including the edge on which out_ready retires it.
- Register 0 always reads 0 and is never forwarded.
- out_dest rules:
  - opcode 0 (R-type): rd (bits 15:11).
  - opcode 3 (JAL): 31.
  - opcode 0x04–0x07 (branches), opcode 0x28–0x2B (stores), opcode 2 (J): 0.
  - Otherwise: rt.
- flush:
  - Forces IDLE at the next edge from any state.
  - out_valid=0 and rf_re=0 in the flush cycle's following cycle.
  - Writeback pass-through is unaffected.
  - flush in IDLE with in_valid: the instruction is not accepted.

## Timing
- Reset (async, rst_n low):
  - state=IDLE.
  - out_valid=0; out_instr, out_pc, out_opA, out_opB, out_dest=0.
  - rf_re=0; in_ready=1.
  - rf_we, rf_regW, rf_dataIn follow wb_* regardless of reset.
- Minimum latency is 3 cycles: accept at edge 0; READ in cycle 1; CAPTURE in cycle 2; out_valid high in cycle 3.
- Each wb_valid cycle during READ adds one cycle.
- Throughput: at most one instruction per 4 cycles; in_ready is low from READ through HOLD.
- Reset deasserted mid-operation: the instruction is discarded; no partial output.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, branch/store ranges);
  - FSM state enum (IDLE, READ, CAPTURE, HOLD);
  - register field bit positions.
- One combinational sub-module, dest_decode (instr[31:0] -> dest[4:0]), reused later by the hazard unit.

## Test plan
- Reset then add $3,$1,$2 (0x00221820), regfile $1=5, $2=7, out_ready=1: out_valid at cycle 3; opA=5, opB=7, dest=3.
- Same instruction with wb_valid ($9) during READ for 2 cycles: out_valid at cycle 5; rf_re low for both wb cycles; $9 written.
- Writeback $1=0xAA in CAPTURE cycle: opA=0xAA, not the old 5. Writeback $0=0xFF: opA/opB unaffected.
- out_ready held 0 for 4 cycles, writeback $2=0x1234 in HOLD: opB becomes 0x1234 next cycle; out_pc/out_instr unchanged; in_ready stays 0.
- Decode: jal -> dest 31; sw -> dest 0; lw $5 -> dest 5; beq -> dest 0.
- flush in CAPTURE: out_valid never rises; in_ready=1 next cycle. rst_n low in HOLD: out_valid drops immediately; outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: opcodes, instruction field positions and
// the operand-fetch FSM states.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BR_LO = 6'h04;
  localparam logic [5:0] OP_BR_HI = 6'h07;
  localparam logic [5:0] OP_ST_LO = 6'h28;
  localparam logic [5:0] OP_ST_HI = 6'h2B;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } of_state_e;

endpackage

// File: rtl/dest_decode.sv
// Destination-register decode for one instruction word; 0 means the
// instruction writes no register.
module dest_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  dest_o
);

  logic [5:0] opcode;
  logic       is_branch;
  logic       is_store;
  logic       unused_bits;

  assign opcode      = instr_i[OPC_MSB:OPC_LSB];
  assign is_branch   = (opcode >= OP_BR_LO) && (opcode <= OP_BR_HI);
  assign is_store    = (opcode >= OP_ST_LO) && (opcode <= OP_ST_HI);
  assign unused_bits = ^{instr_i[RS_MSB:RS_LSB], instr_i[RD_LSB-1:0]};

  always_comb begin
    dest_o = instr_i[RT_MSB:RT_LSB];
    if (opcode == OP_RTYPE) begin
      dest_o = instr_i[RD_MSB:RD_LSB];
    end else if (opcode == OP_JAL) begin
      dest_o = REG_RA;
    end else if ((opcode == OP_J) || is_branch || is_store) begin
      dest_o = REG_ZERO;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: holds one instruction, reads rs/rt from the register
// file, forwards writebacks into captured/held operands, hands off to execute.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic [4:0]  rf_regA,
  output logic [4:0]  rf_regB,
  output logic [4:0]  rf_regW,
  output logic [31:0] rf_dataIn,
  output logic        rf_we,
  output logic        rf_re,
  input  logic [31:0] rf_outA,
  input  logic [31:0] rf_outB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_opA,
  output logic [31:0] out_opB,
  output logic [4:0]  out_dest,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready/out_valid never depend on the partner's valid/ready.

  of_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        fwd_a;
  logic        fwd_b;

  assign rs    = instr_q[RS_MSB:RS_LSB];
  assign rt    = instr_q[RT_MSB:RT_LSB];
  assign fwd_a = wb_valid && (wb_reg != REG_ZERO) && (wb_reg == rs);
  assign fwd_b = wb_valid && (wb_reg != REG_ZERO) && (wb_reg == rt);

  // Write port is a pure pass-through so writeback is never stalled.
  assign rf_regW   = wb_reg;
  assign rf_dataIn = wb_data;
  assign rf_we     = wb_valid;
  assign rf_regA   = rs;
  assign rf_regB   = rt;

  assign out_instr   = instr_q;
  assign out_pc      = pc_q;
  assign out_opA     = opa_q;
  assign out_opB     = opb_q;
  assign dbg_state_o = state_q;

  dest_decode u_dest_decode (
    .instr_i (instr_q),
    .dest_o  (out_dest)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    in_ready  = 1'b0;
    rf_re     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          state_d = READ;
          instr_d = in_instr;
          pc_d    = in_pc;
        end
      end
      READ: begin
        // A writeback owns the single port this cycle; retry next cycle.
        rf_re = !wb_valid;
        if (!wb_valid) state_d = CAPTURE;
      end
      CAPTURE: begin
        opa_d   = fwd_a ? wb_data : ((rs == REG_ZERO) ? 32'd0 : rf_outA);
        opb_d   = fwd_b ? wb_data : ((rt == REG_ZERO) ? 32'd0 : rf_outB);
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (fwd_a) opa_d = wb_data;
        if (fwd_b) opb_d = wb_data;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural single-port register
// file attached to the rf_* ports.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [4:0]  rf_regA;
  logic [4:0]  rf_regB;
  logic [4:0]  rf_regW;
  logic [31:0] rf_dataIn;
  logic        rf_we;
  logic        rf_re;
  logic [31:0] rf_outA;
  logic [31:0] rf_outB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_opA;
  logic [31:0] out_opB;
  logic [4:0]  out_dest;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  operand_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .rf_regA     (rf_regA),
    .rf_regB     (rf_regB),
    .rf_regW     (rf_regW),
    .rf_dataIn   (rf_dataIn),
    .rf_we       (rf_we),
    .rf_re       (rf_re),
    .rf_outA     (rf_outA),
    .rf_outB     (rf_outB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_opA     (out_opA),
    .out_opB     (out_opB),
    .out_dest    (out_dest),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Register file: write has the port whenever rf_we is high; read data
  // appears the cycle after rf_re; register 0 reads 0.
  always @(posedge clk) begin
    if (rf_we && rf_regW != 5'd0) regs[rf_regW] <= rf_dataIn;
    if (rf_re) begin
      rf_outA <= (rf_regA == 5'd0) ? 32'd0 : regs[rf_regA];
      rf_outB <= (rf_regB == 5'd0) ? 32'd0 : regs[rf_regB];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  // Returns in cycle 1 (first cycle after the accepting edge).
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid; lat is the cycle index where it was seen.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h55;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    checks++; if (rf_re !== 1'b0) begin errors++; $display("FAIL reset_rf_re got %0h want 0", rf_re); end
    checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0h want 0", dbg_state_o); end
    checks++; if ({out_instr, out_pc, out_opA, out_opB} !== 128'd0) begin errors++; $display("FAIL reset_outputs got %h %h %h %h want 0", out_instr, out_pc, out_opA, out_opB); end
    checks++; if (out_dest !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", out_dest); end
    checks++; if ({rf_we, rf_regW, rf_dataIn} !== {1'b1, 5'd4, 32'h55}) begin errors++; $display("FAIL reset_wb_passthru got %0h %0d %h want 1 4 55", rf_we, rf_regW, rf_dataIn); end
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int lat;
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    out_ready = 1'b1;
    issue(32'h00221820, 32'h100);
    checks++; if ({rf_re, rf_regA, rf_regB} !== {1'b1, 5'd1, 5'd2}) begin errors++; $display("FAIL basic_read got re=%0h a=%0d b=%0d want 1 1 2", rf_re, rf_regA, rf_regB); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy got %0h want 0", in_ready); end
    wait_valid(1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    checks++; if (out_opA !== 32'd5) begin errors++; $display("FAIL basic_opA got %h want 5", out_opA); end
    checks++; if (out_opB !== 32'd7) begin errors++; $display("FAIL basic_opB got %h want 7", out_opB); end
    checks++; if (out_dest !== 5'd3) begin errors++; $display("FAIL basic_dest got %0d want 3", out_dest); end
    checks++; if ({out_instr, out_pc} !== {32'h00221820, 32'h100}) begin errors++; $display("FAIL basic_instr_pc got %h %h want 00221820 100", out_instr, out_pc); end
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL basic_retire got valid=%0h ready=%0h want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_wb_stall;
    int lat;
    issue(32'h00221820, 32'h104);
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
    #1;
    checks++; if ({rf_re, rf_we, rf_regW} !== {1'b0, 1'b1, 5'd9}) begin errors++; $display("FAIL stall_c1 got re=%0h we=%0h w=%0d want 0 1 9", rf_re, rf_we, rf_regW); end
    tick();
    checks++; if (rf_re !== 1'b0) begin errors++; $display("FAIL stall_c2_rf_re got %0h want 0", rf_re); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (rf_re !== 1'b1) begin errors++; $display("FAIL stall_c3_rf_re got %0h want 1", rf_re); end
    wait_valid(3, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL stall_latency got %0d want 5", lat); end
    checks++; if ({out_opA, out_opB} !== {32'd5, 32'd7}) begin errors++; $display("FAIL stall_ops got %h %h want 5 7", out_opA, out_opB); end
    checks++; if (regs[9] !== 32'h99) begin errors++; $display("FAIL stall_reg9 got %h want 99", regs[9]); end
    tick();
  endtask

  task automatic test_capture_fwd;
    issue(32'h00221820, 32'h108);
    tick();
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'hAA;
    tick();
    wb_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cfwd_valid got %0h want 1", out_valid); end
    checks++; if ({out_opA, out_opB} !== {32'hAA, 32'd7}) begin errors++; $display("FAIL cfwd_ops got %h %h want aa 7", out_opA, out_opB); end
    tick();
    issue(32'h00021820, 32'h10C);
    tick();
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
    tick();
    wb_valid = 1'b0;
    checks++; if ({out_opA, out_opB} !== {32'd0, 32'd7}) begin errors++; $display("FAIL cfwd_r0_ops got %h %h want 0 7", out_opA, out_opB); end
    tick();
  endtask

  task automatic test_hold_stall;
    int lat;
    out_ready = 1'b0;
    issue(32'h00221820, 32'h110);
    wait_valid(1, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL hold_latency got %0d want 3", lat); end
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h1234;
    tick();
    wb_valid = 1'b0;
    checks++; if ({out_opA, out_opB} !== {32'hAA, 32'h1234}) begin errors++; $display("FAIL hold_fwd_ops got %h %h want aa 1234", out_opA, out_opB); end
    checks++; if ({out_instr, out_pc} !== {32'h00221820, 32'h110}) begin errors++; $display("FAIL hold_instr_pc got %h %h want 00221820 110", out_instr, out_pc); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold_stable_%0d got valid=%0h ready=%0h want 1 0", i, out_valid, in_ready); end
    end
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h77;
    tick();
    wb_valid = 1'b0;
    checks++; if ({out_valid, out_opA} !== {1'b0, 32'h77}) begin errors++; $display("FAIL hold_retire_fwd got valid=%0h opA=%h want 0 77", out_valid, out_opA); end
  endtask

  task automatic test_decode;
    logic [31:0] ins_t [5];
    logic [4:0]  dst_t [5];
    int lat;
    ins_t = '{32'h0C000010, 32'hAC250004, 32'h8C250004, 32'h10220003, 32'h08000010};
    dst_t = '{5'd31, 5'd0, 5'd5, 5'd0, 5'd0};
    for (int i = 0; i < 5; i++) begin
      issue(ins_t[i], 32'h200 + 32'(4 * i));
      wait_valid(1, lat);
      checks++; if ({out_valid, out_dest} !== {1'b1, dst_t[i]}) begin errors++; $display("FAIL decode_%0d got valid=%0h dest=%0d want 1 %0d", i, out_valid, out_dest, dst_t[i]); end
      tick();
    end
  endtask

  task automatic test_flush;
    issue(32'h00221820, 32'h300);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({out_valid, in_ready, rf_re, dbg_state_o} !== {3'b010, 2'd0}) begin errors++; $display("FAIL flush_capture got valid=%0h ready=%0h re=%0h st=%0d want 0 1 0 0", out_valid, in_ready, rf_re, dbg_state_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_valid_%0d got %0h want 0", i, out_valid); end
    end
    in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h304; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if ({dbg_state_o, rf_re, in_ready} !== {2'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL flush_idle got st=%0d re=%0h ready=%0h want 0 0 1", dbg_state_o, rf_re, in_ready); end
  endtask

  task automatic test_reset_hold;
    int lat;
    issue(32'h00221820, 32'h400);
    wait_valid(1, lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rsth_pre_valid got %0h want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rsth_ctrl got valid=%0h ready=%0h want 0 1", out_valid, in_ready); end
    checks++; if ({out_instr, out_pc, out_opA, out_opB, out_dest} !== 133'd0) begin errors++; $display("FAIL rsth_outputs got %h %h %h %h %0d want 0", out_instr, out_pc, out_opA, out_opB, out_dest); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(32'h00221820, 32'h404);
    wait_valid(1, lat);
    checks++; if ({lat[4:0], out_opA, out_opB} !== {5'd3, 32'h77, 32'h1234}) begin errors++; $display("FAIL rsth_after got lat=%0d %h %h want 3 77 1234", lat, out_opA, out_opB); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wb_stall();
    test_capture_fwd();
    test_hold_stall();
    test_decode();
    test_flush();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
